// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, fault codes,
// controller states and the request fault classifier.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;
  localparam logic [1:0] FLT_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Classify a request; earlier checks take priority over later ones.
  function automatic logic [1:0] calc_fault(input logic [1:0] size,
                                            input logic       out_of_range,
                                            input logic [1:0] addr_lo);
    if (size == SZ_ILLEGAL)                      return FLT_SIZE;
    if (out_of_range)                            return FLT_RANGE;
    if ((size == SZ_HALF && addr_lo[0]) ||
        (size == SZ_WORD && addr_lo != 2'b00))   return FLT_MISALIGN;
    return FLT_NONE;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering. The store path turns right-justified data
// into a replicated write word plus lane enables; the load path picks the
// addressed lane out of a raw RAM word and sign/zero-extends it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] st_data_i,
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_offs_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_word_o,
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_offs_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  assign ld_shifted = ld_word_i >> {ld_offs_i, 3'b000};

  // Store path: replicate the datum into every lane it may occupy and enable
  // only the addressed lanes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (latch).
    st_be_o   = 4'b0000;
    st_word_o = st_data_i;
    unique case (st_size_i)
      SZ_BYTE: begin
        st_be_o   = 4'b0001 << st_offs_i;
        st_word_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o   = st_offs_i[1] ? 4'b1100 : 4'b0011;
        st_word_o = {2{st_data_i[15:0]}};
      end
      SZ_WORD: st_be_o = 4'b1111;
      default: st_be_o = 4'b0000;
    endcase
  end

  // Load path: shift the addressed lane down, then extend.
  always_comb begin
    ld_data_o = 32'h0;
    unique case (ld_size_i)
      SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_shifted[7:0]}
                                         : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_shifted[15:0]}
                                         : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_WORD: ld_data_o = ld_word_i;
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request channel in front of a
// word-wide RAM, one outstanding access, optional read wait-states, and
// registered response with fault code.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault
);

  localparam int          IW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS_LOAD     = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] offset;
  logic [IW-1:0] idx;
  logic        out_of_range;
  logic [1:0]  req_flt;
  logic        accept;
  logic        wr_en;

  logic [3:0]  st_be;
  logic [31:0] st_word;
  logic [31:0] ld_data;

  logic [31:0] hold_word_q;
  logic        hold_we_q;
  logic [1:0]  hold_size_q;
  logic        hold_uns_q;
  logic [1:0]  hold_lo_q;
  logic [1:0]  hold_flt_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Addresses below the base wrap to huge offsets and land in the range fault.
  assign offset       = req_addr - BASE_ADDR;
  assign idx          = offset[IW+1:2];
  assign out_of_range = {1'b0, offset} >= RANGE_BYTES;
  assign req_flt      = calc_fault(req_size, out_of_range, req_addr[1:0]);
  assign accept       = req_valid && req_ready;
  assign wr_en        = accept && req_we && (req_flt == FLT_NONE);

  dmem_lane_align u_align (
    .st_data_i     (req_wdata),
    .st_size_i     (req_size),
    .st_offs_i     (req_addr[1:0]),
    .st_be_o       (st_be),
    .st_word_o     (st_word),
    .ld_word_i     (hold_word_q),
    .ld_size_i     (hold_size_q),
    .ld_offs_i     (hold_lo_q),
    .ld_unsigned_i (hold_uns_q),
    .ld_data_o     (ld_data)
  );

  // RAM: byte-lane write and synchronous read, both at the accept edge.
  // NOTE: RAM and its read register carry no reset so the array maps onto a
  // real memory macro; nothing downstream observes them outside RESP.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[idx][b*8 +: 8] <= st_word[b*8 +: 8];
      end
    end
    if (accept) hold_word_q <= mem_q[idx];
  end

  // State and wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request attributes needed to format the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_we_q   <= 1'b0;
      hold_size_q <= SZ_WORD;
      hold_uns_q  <= 1'b0;
      hold_lo_q   <= 2'b00;
      hold_flt_q  <= FLT_NONE;
    end else if (accept) begin
      hold_we_q   <= req_we;
      hold_size_q <= req_size;
      hold_uns_q  <= req_unsigned;
      hold_lo_q   <= req_addr[1:0];
      hold_flt_q  <= req_flt;
    end
  end

  // Outputs depend only on state and holding registers, never on req_*.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_fault = rsp_valid ? hold_flt_q : FLT_NONE;
    rsp_rdata = (rsp_valid && !hold_we_q && hold_flt_q == FLT_NONE) ? ld_data : 32'h0;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with no wait-states, one with three.
// Table vectors run through a request/response task with a scoreboard queue;
// hand sequences cover response back-pressure and reset during WAIT.
module tb_dmem_ctrl;

  typedef struct {
    int          d;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  flt;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  flt;
  } exp_t;

  localparam int WS [2] = '{0, 3};

  logic        clk = 1'b0;
  logic        rst_n        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic [1:0]  rsp_fault    [2];

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb [$];
  vec_t vecs [$];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] flt);
    vec_t v;
    v.d = d; v.we = we; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.flt = flt;
    return v;
  endfunction

  // Drive one request, push its expectation at the accept edge, and wait
  // (bounded) for the response, which is popped and compared.
  // rsp_ready is held high from the start, so the RESP cycle is still seen.
  task automatic xact(input vec_t v, input string name, input logic hold_off);
    int   d = v.d;
    int   lat = 0;
    exp_t e;
    @(negedge clk);
    check({name, ".req_ready_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d]    = 1'b1;
    req_we[d]       = v.we;
    req_size[d]     = v.size;
    req_unsigned[d] = v.uns;
    req_addr[d]     = v.addr;
    req_wdata[d]    = v.wdata;
    rsp_ready[d]    = !hold_off;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    e.rdata = v.rdata;
    e.flt   = v.flt;
    sb.push_back(e);
    forever begin
      @(negedge clk);
      if (rsp_valid[d]) break;
      check({name, ".req_ready_busy"}, 32'(req_ready[d]), 32'd0);
      lat++;
      if (lat > 40) begin
        check({name, ".timeout"}, 32'd0, 32'd1);
        sb.delete();
        return;
      end
    end
    check({name, ".latency"}, 32'(lat), 32'(WS[d]));
    if (sb.size() == 0) begin
      check({name, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({name, ".rdata"}, rsp_rdata[d], e.rdata);
    check({name, ".fault"}, 32'(rsp_fault[d]), 32'(e.flt));
    if (hold_off) begin
      // Two edges with rsp_ready low: response must not move.
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check($sformatf("%s.stall%0d_valid", name, i), 32'(rsp_valid[d]), 32'd1);
        check($sformatf("%s.stall%0d_rdata", name, i), rsp_rdata[d], e.rdata);
        check($sformatf("%s.stall%0d_fault", name, i), 32'(rsp_fault[d]), 32'(e.flt));
        check($sformatf("%s.stall%0d_ready", name, i), 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      check({name, ".release_valid"}, 32'(rsp_valid[d]), 32'd0);
      check({name, ".release_ready"}, 32'(req_ready[d]), 32'd1);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b10;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d.req_ready", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset%0d.rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset%0d.rsp_rdata", d), rsp_rdata[d], 32'h0);
      check($sformatf("reset%0d.rsp_fault", d), 32'(rsp_fault[d]), 32'd0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    //               d  we  size   uns  addr           wdata          rdata          flt
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1001_0000, 32'h0,         32'hDEAD_BEEF, 2'b00));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h1001_0003, 32'h1234_5680, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h1001_0003, 32'h0,         32'hFFFF_FF80, 2'b00));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h1001_0003, 32'h0,         32'h0000_0080, 2'b00));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1001_0000, 32'h0,         32'h80AD_BEEF, 2'b00));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h1001_0002, 32'h0,         32'hFFFF_80AD, 2'b00));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h1001_0001, 32'h0000_FFFF, 32'h0000_0000, 2'b01));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1001_0000, 32'h0,         32'h80AD_BEEF, 2'b00));
    vecs.push_back(mk(0, 0, 2'b11, 0, 32'h1001_0000, 32'h0,         32'h0000_0000, 2'b11));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1000_FFFC, 32'h0,         32'h0000_0000, 2'b10));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1001_4000, 32'h0,         32'h0000_0000, 2'b10));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h1001_3FFC, 32'hCAFE_F00D, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1001_3FFC, 32'h0,         32'hCAFE_F00D, 2'b00));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h1001_0000, 32'h0,         32'h0000_BEEF, 2'b00));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h1001_0000, 32'h0,         32'hFFFF_BEEF, 2'b00));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h1001_0001, 32'h0,         32'hFFFF_FFBE, 2'b00));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1001_0002, 32'h0,         32'h0000_0000, 2'b01));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h1001_0002, 32'hABCD_1234, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1001_0000, 32'h0,         32'h1234_BEEF, 2'b00));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h1000_FFFC, 32'h5555_5555, 32'h0000_0000, 2'b11));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h1001_4001, 32'h0,         32'h0000_0000, 2'b10));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h1001_0020, 32'h0BAD_F00D, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h1001_0020, 32'h0,         32'h0BAD_F00D, 2'b00));
    vecs.push_back(mk(1, 0, 2'b00, 1, 32'h1001_0021, 32'h0,         32'h0000_00F0, 2'b00));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h1000_FFFC, 32'h0,         32'h0000_0000, 2'b10));

    foreach (vecs[i]) xact(vecs[i], $sformatf("v%0d", i), 1'b0);

    // Reset pulsed while a store sits in WAIT on the wait-state instance.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h1001_0010; req_wdata[1] = 32'h1234_5678; rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    sb.push_back('{rdata: 32'h0, flt: 2'b00});
    @(negedge clk);
    check("rst_mid.in_wait_ready", 32'(req_ready[1]), 32'd0);
    check("rst_mid.in_wait_valid", 32'(rsp_valid[1]), 32'd0);
    #2 rst_n[1] = 1'b0;
    #1;
    sb.delete();
    check("rst_mid.rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_mid.rsp_rdata", rsp_rdata[1], 32'h0);
    check("rst_mid.rsp_fault", 32'(rsp_fault[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    check("rst_mid.req_ready", 32'(req_ready[1]), 32'd1);
    xact(mk(1, 0, 2'b10, 0, 32'h1001_0010, 32'h0, 32'h1234_5678, 2'b00), "rst_mid.lw", 1'b0);

    // Back-pressure: response held two edges with rsp_ready low.
    xact(mk(1, 0, 2'b10, 0, 32'h1001_0010, 32'h0, 32'h1234_5678, 2'b00), "stall.lw", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory; adds byte/halfword/word access, a valid/ready request channel, a response channel, programmable read wait-states, and alignment/range fault reporting.
- Sits between the MIPS MEM stage (or the multicycle controller) and the data RAM.
- Processor stalls on req_ready/rsp_valid instead of assuming zero-latency access.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words; must be a power of 2; index width = $clog2(DEPTH_WORDS).
- BASE_ADDR, 32'h1001_0000, byte address of word 0.
- WAIT_STATES, 0, extra cycles (0..15) between accept and response.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=00, wait counter=0. RAM contents are not reset.
- Little-endian byte lanes: addr[1:0]=0 maps to bits [7:0], addr[1:0]=3 maps to bits [31:24].
- offset = req_addr - BASE_ADDR as 32-bit unsigned; addresses below the base wrap to large values and fault as out of range.
- Word index = offset[idx+1:2].
- Fault checks, in priority order:
  - size 11 -> 11.
  - offset >= DEPTH_WORDS*4 -> 10.
  - half with addr[0]=1, or word with addr[1:0]!=0 -> 01.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1. Accept on a rising edge where req_valid=1 (edge k).
  - Store with no fault: write only the selected byte lanes at edge k; all other lanes and words are unchanged.
  - Any faulting request: no RAM write.
  - Load: RAM word read synchronously at edge k into a holding register, together with size, unsigned, addr[1:0] and fault.
  - If WAIT_STATES=0, go to RESP. Otherwise load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT: req_ready=0; counter decrements each edge; at 0 go to RESP. rsp_valid is therefore first high in the cycle after edge k+WAIT_STATES.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_fault stay stable until rsp_ready=1.
  - Go to IDLE on the edge where rsp_ready=1. Holding rsp_ready=1 beforehand still costs at least one RESP cycle.
- Load formatting: lane selected by addr[1:0], then extended to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Only one request is outstanding at a time; req_ready=0 in WAIT and RESP. Minimum throughput is one request per 2+WAIT_STATES cycles.
- Store then load to the same address returns the new data, because the write completes at its accept edge.
- Reset mid-operation: pending response is dropped, outputs return to reset values immediately, and an already-accepted store stays written.
- Outputs are registered or decoded from state only; there is no combinational path from req_* to rsp_*.

Decomposition:
- Package dmem_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - fault codes (FLT_NONE, FLT_MISALIGN, FLT_RANGE, FLT_SIZE).
  - state enum (IDLE, WAIT, RESP).
- Sub-module dmem_lane_align (combinational):
  - store path: data+size+addr[1:0] -> 4-bit lane enable plus replicated write word.
  - load path: raw word+size+addr[1:0]+unsigned -> extended result.
  - Shared by both paths and reusable by a future cache.

Test Plan:
- WAIT_STATES=0: sw 0xDEADBEEF @0x10010000, then lw from the same address -> rsp_rdata=0xDEADBEEF, fault 00, rsp_valid high the cycle after accept.
- sb 0x80 @0x10010003:
  - lb -> 0xFFFFFF80.
  - lbu -> 0x00000080.
  - lw @0x10010000 -> 0x80ADBEEF.
  - lh @0x10010002 -> 0xFFFF80AD.
- sh @0x10010001 -> fault 01; following lw @0x10010000 still 0x80ADBEEF. req_size=11 -> fault 11, rdata 0.
- Range boundaries:
  - lw @0x1000FFFC -> fault 10.
  - lw @0x10014000 -> fault 10.
  - lw @0x10013FFC -> fault 00.
- WAIT_STATES=3: accept at edge k -> rsp_valid first high after edge k+3. req_ready=0 throughout. rsp_ready held low 2 cycles -> rsp held stable, then IDLE one edge after rsp_ready=1.
- rst_n pulsed low during WAIT after a sw 0x12345678 -> rsp_valid=0 immediately, req_ready=1 after release, subsequent lw returns 0x12345678.
